// File: rtl/bitstream_pkg.sv
// bitstream_pkg: FSM state type and default window length shared by the decoder and the bitstream generators.
package bitstream_pkg;
  localparam int BS_WINDOW_DEFAULT = 256;
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } bs_state_e;
endpackage

// File: rtl/bitstream_counter.sv
// bitstream_counter: ones accumulator plus window-position counter; last flags the final sample of a window.
module bitstream_counter
  import bitstream_pkg::*;
#(
  parameter int WINDOW = BS_WINDOW_DEFAULT,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             x,
  output logic [CNT_W-1:0] count,
  output logic             last
);
  logic [CNT_W-1:0] count_q, win_q;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      win_q   <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(x);
      win_q   <= win_q + CNT_W'(1);
    end
  end
  assign count = count_q;
  assign last  = en && (win_q == CNT_W'(WINDOW - 1));
endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts ones of a stochastic bitstream over WINDOW cycles per conversion.
// Define BITSTREAM_DECODER_CONTINUOUS_EN to restart windows back-to-back until reset.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int WINDOW = BS_WINDOW_DEFAULT,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x,
  output logic             busy,
  output logic [CNT_W-1:0] value,
  output logic             valid
);
  bs_state_e        state_q;
  logic             busy_q, valid_q, clear, en, last, wrap;
  logic [CNT_W-1:0] value_q, count;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
  assign wrap = last;
`else
  assign wrap = 1'b0;
`endif
  assign en    = state_q == COUNT;
  assign clear = (state_q == IDLE && start) || wrap;
  bitstream_counter #(.WINDOW(WINDOW)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (en),
    .x     (x),
    .count (count),
    .last  (last)
  );
  // The final sample is folded in directly so value is ready one cycle after the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
    end else begin
      valid_q <= last;
      if (last) value_q <= count + CNT_W'(x);
      if (state_q == IDLE && start) begin
        state_q <= COUNT;
        busy_q  <= 1'b1;
      end else if (last && !wrap) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end
  assign busy  = busy_q;
  assign value = value_q;
  assign valid = valid_q;
endmodule
